ahb_verilog_slave: RTL and testbench
====================================

# ahb_verilog_slave

Memory-backed AHB slave that serves as the responder for the AHB Verilog master traffic generators in the qvip_ahb_example bench. It decodes the address phase, inserts a programmable number of wait states, and services full-word reads and writes from an internal word array. It returns a two-cycle ERROR response for out-of-range or unsupported accesses and exposes completed-transfer counters for scoreboarding.

## Interface
- AHB_ADDRESS_WIDTH, 32, HADDR width
- AHB_WDATA_WIDTH, 32, HWDATA width
- AHB_RDATA_WIDTH, 32, HRDATA width; must equal AHB_WDATA_WIDTH
- MEM_DEPTH, 2048, number of words; power of two
- WAIT_STATES, 0, HREADYOUT-low cycles per OKAY data phase (0..15)

Ports:
- HCLK  input  1  bus clock; all logic on rising edge
- HRESET  input  1  reset, asynchronous, active-high (one clock; reset is asynchronous and active-high)
- HSEL  input  1  slave select
- HADDR  input  AHB_ADDRESS_WIDTH  word index (word-addressed, as driven by the team's masters)
- HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  input  1  1=write
- HSIZE  input  3  transfer size
- HBURST  input  3  accepted, not used for decode
- HPROT  input  4  accepted, ignored
- HWDATA  input  AHB_WDATA_WIDTH  write data, data phase
- HREADY  input  1  bus-level ready (muxed)
- HREADYOUT  output  1  slave ready
- HRESP  output  2  OKAY=00, ERROR=01; RETRY/SPLIT never driven
- HRDATA  output  AHB_RDATA_WIDTH  read data
- XFER_COUNT  output  16  completed OKAY transfers, wraps at 0xFFFF→0
- ERR_COUNT  output  8  ERROR responses issued, saturates at 0xFF

## Operation
- Transfer accepted on a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1; HADDR, HWRITE and HSIZE are captured.
- IDLE/BUSY, or HSEL=0 with HREADY=1: no access; the next data phase is OKAY with zero waits.
- Error conditions, checked on the captured phase: HADDR >= MEM_DEPTH, or HSIZE encoding larger than log2(AHB_WDATA_WIDTH/8).
- Legal accesses are always full-word; smaller HSIZE reads or writes the whole word at index HADDR.
- FSM states:
  - IDLE: no data phase pending.
  - WAIT: counter counting down.
  - DATA: HREADYOUT=1, OKAY.
  - ERR1: HREADYOUT=0, HRESP=01.
  - ERR2: HREADYOUT=1, HRESP=01.
- FSM transitions:
  - Accept legal with WAIT_STATES=0 → DATA.
  - Accept legal with WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES; WAIT → DATA when counter reaches 1.
  - Accept illegal → ERR1 → ERR2.
  - DATA or ERR2 with a new accept → the state for that transfer; otherwise → IDLE.
- Write: the memory word is updated with HWDATA on the edge that completes DATA (HREADYOUT=1).
- Read: HRDATA is registered from memory and valid throughout DATA. Write-to-read forwarding is required: a read accepted on the same edge a write to the same index completes returns the new HWDATA.
- Errored writes do not modify memory. Errored reads drive HRDATA=0.
- XFER_COUNT increments on each DATA completion; ERR_COUNT increments on each ERR2 completion.
- A master cancelling after ERR1 (driving IDLE in ERR2) requires no special handling.
- Memory contents are zero at time zero and are not cleared by HRESET.

## Timing
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, XFER_COUNT=0, ERR_COUNT=0, FSM=IDLE, wait counter=0.
- Reset asserted mid-transfer aborts it immediately: a pending write is discarded and no counter increments.
- Zero-wait OKAY: the data phase completes one cycle after address acceptance; pipelined back-to-back transfers sustain one transfer per cycle.
- WAIT_STATES=N: HREADYOUT low for exactly N cycles, then high for one cycle.
- HRDATA is updated only when entering DATA and holds its value otherwise.
- ERROR: exactly two cycles, HREADYOUT 0 then 1, with HRESP=01 in both. HRESP returns to 00 in the following cycle unless another error follows.
- New address phases are ignored while HREADYOUT=0 (HREADY is low bus-wide).

## Test plan
- Reset then write NONSEQ HADDR=10 with HWDATA=0x0000000B (WAIT_STATES=0), then read 10 → HRDATA=0x0000000B, HRESP=00, XFER_COUNT=2.
- Back-to-back pipelined write 768=0x301 then read 768 on the next cycle → forwarded HRDATA=0x301, no stall.
- WAIT_STATES=3, single read → HREADYOUT low 3 cycles, high on the 4th cycle with valid data.
- Write to HADDR=2048 → HRESP=01 for two cycles (HREADYOUT 0,1); memory unchanged; ERR_COUNT=1; following IDLE gives OKAY.
- INCR4 burst of SEQ writes at 764..767, then read back → values match; XFER_COUNT += 8.
- Assert HRESET during a WAIT data phase of a write → HREADYOUT=1 and HRESP=00 immediately; the target word keeps its old value.

Source files
------------

// File: rtl/ahb_verilog_slave.sv
// Word-addressed, memory-backed AHB slave: programmable wait states, two-cycle
// ERROR responses for bad accesses, and completed-transfer/error counters.
module ahb_verilog_slave #(
    parameter int AHB_ADDRESS_WIDTH = 32,
    parameter int AHB_WDATA_WIDTH   = 32,
    parameter int AHB_RDATA_WIDTH   = 32,
    parameter int MEM_DEPTH         = 2048,
    parameter int WAIT_STATES       = 0
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic                         HSEL,
    input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    input  logic [2:0]                   HSIZE,
    input  logic [2:0]                   HBURST,
    input  logic [3:0]                   HPROT,
    input  logic [AHB_WDATA_WIDTH-1:0]   HWDATA,
    input  logic                         HREADY,
    output logic                         HREADYOUT,
    output logic [1:0]                   HRESP,
    output logic [AHB_RDATA_WIDTH-1:0]   HRDATA,
    output logic [15:0]                  XFER_COUNT,
    output logic [7:0]                   ERR_COUNT
);

    localparam int IDX_W    = $clog2(MEM_DEPTH);
    localparam int SIZE_MAX = $clog2(AHB_WDATA_WIDTH / 8);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

    state_e                     state_q, state_d;
    logic [3:0]                 wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]           addr_q, addr_d;
    logic                       write_q, write_d;
    logic [AHB_RDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [15:0]                xfer_cnt_q, xfer_cnt_d;
    logic [7:0]                 err_cnt_q, err_cnt_d;

    logic [AHB_WDATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic             accept;
    logic             legal;
    logic             fwd_hit;
    logic [IDX_W-1:0] haddr_idx;
    logic             unused_inputs;

    assign haddr_idx     = HADDR[IDX_W-1:0];
    assign unused_inputs = ^{HBURST, HPROT};

    assign HREADYOUT  = (state_q != S_WAIT) && (state_q != S_ERR1);
    assign HRESP      = (state_q == S_ERR1 || state_q == S_ERR2) ? RESP_ERROR : RESP_OKAY;
    assign HRDATA     = rdata_q;
    assign XFER_COUNT = xfer_cnt_q;
    assign ERR_COUNT  = err_cnt_q;

    // Our own HREADYOUT gates acceptance so a stalled data phase never drops an address phase.
    assign accept  = HSEL && HREADY && HTRANS[1] && HREADYOUT;
    assign legal   = (HADDR < AHB_ADDRESS_WIDTH'(MEM_DEPTH)) && (HSIZE <= 3'(SIZE_MAX));
    assign fwd_hit = (state_q == S_DATA) && write_q && (addr_q == haddr_idx);

    // NOTE: every signal written here gets its default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        rdata_d    = rdata_q;
        xfer_cnt_d = xfer_cnt_q;
        err_cnt_d  = err_cnt_q;

        unique case (state_q)
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    state_d = S_DATA;
                    if (!write_q) rdata_d = mem[addr_q];
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_DATA) xfer_cnt_d = xfer_cnt_q + 16'd1;
        if (state_q == S_ERR2 && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;

        if (accept) begin
            addr_d  = haddr_idx;
            write_d = HWRITE;
            if (!legal) begin
                state_d = S_ERR1;
                if (!HWRITE) rdata_d = '0;
            end else if (WAIT_STATES == 0) begin
                state_d = S_DATA;
                if (!HWRITE) rdata_d = fwd_hit ? HWDATA : mem[haddr_idx];
            end else begin
                state_d    = S_WAIT;
                wait_cnt_d = 4'(WAIT_STATES);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            rdata_q    <= '0;
            xfer_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            rdata_q    <= rdata_d;
            xfer_cnt_q <= xfer_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // NOTE: the word array is deliberately not reset; contents survive HRESET and it can map onto RAM.
    always_ff @(posedge HCLK) begin
        if (state_q == S_DATA && write_q) mem[addr_q] <= HWDATA;
    end

endmodule

// File: tb/tb_ahb_verilog_slave.sv
// Randomized + directed scoreboard bench for ahb_verilog_slave: one zero-wait
// slave and one three-wait slave share a single AHB master bus.
module tb_ahb_verilog_slave;

    localparam int MEM_DEPTH = 2048;
    localparam int WS_B      = 3;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        hreset, hsel, hwrite, sel_b;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    logic        ro_a, ro_b, hready_bus;
    logic [1:0]  resp_a, resp_b;
    logic [31:0] rdata_a, rdata_b;
    logic [15:0] xfer_a, xfer_b;
    logic [7:0]  errc_a, errc_b;

    logic        act_ro;
    logic [1:0]  act_resp;
    logic [31:0] act_rdata;

    assign act_ro     = sel_b ? ro_b : ro_a;
    assign act_resp   = sel_b ? resp_b : resp_a;
    assign act_rdata  = sel_b ? rdata_b : rdata_a;
    assign hready_bus = act_ro;

    ahb_verilog_slave #(.MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(0)) u_dut_a (
        .HCLK(HCLK), .HRESET(hreset), .HSEL(hsel && !sel_b), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HWDATA(hwdata), .HREADY(hready_bus),
        .HREADYOUT(ro_a), .HRESP(resp_a), .HRDATA(rdata_a),
        .XFER_COUNT(xfer_a), .ERR_COUNT(errc_a)
    );

    ahb_verilog_slave #(.MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(WS_B)) u_dut_b (
        .HCLK(HCLK), .HRESET(hreset), .HSEL(hsel && sel_b), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HWDATA(hwdata), .HREADY(hready_bus),
        .HREADYOUT(ro_b), .HRESP(resp_b), .HRDATA(rdata_b),
        .XFER_COUNT(xfer_b), .ERR_COUNT(errc_b)
    );

    typedef struct {
        logic        is_err;
        logic        chk_data;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b1;
    logic [31:0] mem_m [bit [32:0]];
    logic [15:0] xfer_m [2];
    logic [7:0]  err_m [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Waits for the rising edge at which the bus is ready, then steps #1 past it.
    task automatic wait_accept_edge();
        logic rdy;
        int   n;
        rdy = 1'b0;
        n   = 0;
        while (!rdy) begin
            @(negedge HCLK);
            rdy = hready_bus;
            @(posedge HCLK);
            n++;
            if (!rdy && n > 50) begin
                fail_bound("hready_timeout");
                rdy = 1'b1;
            end
        end
        #1;
    endtask

    // Drives one address phase; the reference model decides the expected data phase.
    task automatic issue(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input logic [2:0] burst);
        exp_t      e;
        int        s;
        bit [32:0] key;
        s = sel_b ? 1 : 0;
        hsel = sel; htrans = trans; hwrite = wr; haddr = addr; hsize = size; hburst = burst;
        wait_accept_edge();
        hwdata     = wdata;
        e.is_err   = 1'b0;
        e.chk_data = 1'b0;
        e.rdata    = '0;
        e.waits    = 0;
        key        = {sel_b, addr};
        if (sel && trans[1]) begin
            if (addr >= 32'(MEM_DEPTH) || size > 3'd2) begin
                e.is_err   = 1'b1;
                e.waits    = 1;
                e.chk_data = !wr;
                if (err_m[s] != 8'hFF) err_m[s] = err_m[s] + 8'd1;
            end else begin
                e.waits   = (s == 1) ? WS_B : 0;
                xfer_m[s] = xfer_m[s] + 16'd1;
                if (wr) mem_m[key] = wdata;
                else begin
                    e.chk_data = 1'b1;
                    e.rdata    = mem_m.exists(key) ? mem_m[key] : 32'h0;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [31:0] data);
        issue(1'b1, T_NONSEQ, 1'b1, addr, 3'd2, data, 3'd0);
    endtask

    task automatic rd_word(input logic [31:0] addr);
        issue(1'b1, T_NONSEQ, 1'b0, addr, 3'd2, $urandom, 3'd0);
    endtask

    task automatic idle();
        issue(1'b0, T_IDLE, 1'b0, 32'h0, 3'd2, 32'h0, 3'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge HCLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_bound("drain_timeout");
            exp_q.delete();
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_counts();
        check("xfer_count_a", 32'(xfer_a), 32'(xfer_m[0]));
        check("err_count_a", 32'(errc_a), 32'(err_m[0]));
        check("xfer_count_b", 32'(xfer_b), 32'(xfer_m[1]));
        check("err_count_b", 32'(errc_b), 32'(err_m[1]));
    endtask

    task automatic rand_run(input int n);
        logic [1:0]  tr;
        logic [31:0] addr;
        logic [2:0]  size;
        int          r;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 9));
            tr = (r == 0) ? T_IDLE : (r == 1) ? T_BUSY : (r < 6) ? T_NONSEQ : T_SEQ;
            r = int'($urandom_range(0, 19));
            addr = (r == 0) ? 32'(MEM_DEPTH) + $urandom_range(0, 1000) :
                   (r == 1) ? 32'(MEM_DEPTH - 1) : 32'($urandom_range(0, 63));
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            issue($urandom_range(0, 19) != 0, tr, 1'($urandom_range(0, 1)), addr, size,
                  $urandom, 3'($urandom_range(0, 7)));
        end
        idle();
        drain();
    endtask

    // Monitor: measures each data phase of the selected slave and compares it with the queue head.
    initial begin : monitor
        int         low_cnt;
        logic       low_resp_ok;
        exp_t       e;
        logic [1:0] exp_resp;
        low_cnt     = 0;
        low_resp_ok = 1'b1;
        forever begin
            @(negedge HCLK);
            if (!mon_en) begin
                low_cnt     = 0;
                low_resp_ok = 1'b1;
                continue;
            end
            if (exp_q.size() == 0) continue;
            exp_resp = exp_q[0].is_err ? 2'b01 : 2'b00;
            if (!act_ro) begin
                low_cnt++;
                if (act_resp != exp_resp) low_resp_ok = 1'b0;
                if (low_cnt > 40) begin
                    fail_bound("data_phase_stall");
                    void'(exp_q.pop_front());
                    low_cnt = 0;
                end
            end else begin
                e = exp_q.pop_front();
                check("hresp", 32'(act_resp), 32'(exp_resp));
                check("wait_cycles", low_cnt, e.waits);
                if (low_cnt > 0) check("hresp_while_low", 32'(low_resp_ok), 32'd1);
                if (e.chk_data) check("hrdata", act_rdata, e.rdata);
                low_cnt     = 0;
                low_resp_ok = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [15:0] xfer_before;
        hreset = 1'b1; hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0; haddr = '0;
        hsize = 3'd2; hburst = '0; hprot = 4'h3; hwdata = '0; sel_b = 1'b0;
        xfer_m[0] = '0; xfer_m[1] = '0; err_m[0] = '0; err_m[1] = '0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_hreadyout_a", 32'(ro_a), 32'd1);
        check("rst_hresp_a", 32'(resp_a), 32'd0);
        check("rst_hrdata_a", rdata_a, 32'd0);
        check("rst_hreadyout_b", 32'(ro_b), 32'd1);
        check("rst_hresp_b", 32'(resp_b), 32'd0);
        check("rst_hrdata_b", rdata_b, 32'd0);
        check_counts();
        hreset = 1'b0;
        @(posedge HCLK);
        #1;

        // Basic write/read, then pipelined write followed by a forwarded read.
        wr_word(32'd10, 32'h0000_000B);
        rd_word(32'd10);
        idle();
        drain();
        check("xfer_after_basic", 32'(xfer_a), 32'd2);
        wr_word(32'd768, 32'h0000_0301);
        rd_word(32'd768);
        idle();
        drain();

        // Out-of-range write leaves index 0 alone; errored read returns zero.
        wr_word(32'd0, 32'hA5A5_5A5A);
        wr_word(32'd2048, 32'hDEAD_BEEF);
        idle();
        drain();
        check("err_count_first", 32'(errc_a), 32'd1);
        rd_word(32'd0);
        rd_word(32'd2048);
        wr_word(32'd2047, 32'h7FF0_07FF);
        rd_word(32'd2047);
        issue(1'b1, T_NONSEQ, 1'b1, 32'd12, 3'd3, 32'h1111_2222, 3'd0);
        idle();
        drain();
        check_counts();

        // INCR4 write burst, then INCR4 read burst.
        xfer_before = xfer_a;
        for (int i = 0; i < 4; i++)
            issue(1'b1, (i == 0) ? T_NONSEQ : T_SEQ, 1'b1, 32'(764 + i), 3'd2, 32'hB000_0000 + 32'(i), 3'b011);
        for (int i = 0; i < 4; i++)
            issue(1'b1, (i == 0) ? T_NONSEQ : T_SEQ, 1'b0, 32'(764 + i), 3'd2, 32'h0, 3'b011);
        idle();
        drain();
        check("burst_xfer_delta", 32'(xfer_a - xfer_before), 32'd8);

        rand_run(250);
        check_counts();

        // Switch to the wait-state slave.
        sel_b = 1'b1;
        wr_word(32'd5, 32'h0000_0055);
        rd_word(32'd5);
        idle();
        drain();
        rand_run(120);
        check_counts();

        // Reset during the WAIT phase of a write discards it.
        wr_word(32'd20, 32'h1234_5678);
        idle();
        drain();
        mon_en = 1'b0;
        hsel = 1'b1; htrans = T_NONSEQ; hwrite = 1'b1; haddr = 32'd20; hsize = 3'd2; hburst = '0;
        wait_accept_edge();
        hsel = 1'b0; htrans = T_IDLE; hwdata = 32'hBAD0_BAD0;
        @(negedge HCLK);
        check("wait_phase_low", 32'(ro_b), 32'd0);
        #2 hreset = 1'b1;
        #1;
        check("midrst_hreadyout", 32'(ro_b), 32'd1);
        check("midrst_hresp", 32'(resp_b), 32'd0);
        check("midrst_xfer", 32'(xfer_b), 32'd0);
        @(posedge HCLK);
        #1 hreset = 1'b0;
        xfer_m[0] = '0; xfer_m[1] = '0; err_m[0] = '0; err_m[1] = '0;
        mon_en = 1'b1;
        rd_word(32'd20);
        idle();
        drain();
        check_counts();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
